// File: rtl/reg_write_arb_pkg.sv
// Shared definitions for the register write arbiter slice.
//   arb_state_e : arbiter FSM states (ARB = arbitrate, OWN = grant held)
//   idx_w()     : width of a requester index (at least 1 bit)
//   DEF_*       : default NREQ / DW / MAX_HOLD values
package reg_write_arb_pkg;

    typedef enum logic {
        ARB = 1'b0,
        OWN = 1'b1
    } arb_state_e;

    localparam int unsigned DEF_NREQ     = 4;
    localparam int unsigned DEF_DW       = 8;
    localparam int unsigned DEF_MAX_HOLD = 4;

    // A single requester still needs a 1-bit index so ports never collapse to zero width.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/reg_write_arbiter_rr_pick.sv
// rr_pick: combinational rotate-priority encoder.
//   req     [NREQ-1:0] : request vector
//   ptr     [IW-1:0]   : highest-priority index for this round
//   winner  [IW-1:0]   : first set request at or after ptr, wrapping modulo NREQ
//   any_req            : at least one request is set (winner valid)
module rr_pick
    import reg_write_arb_pkg::*;
#(
    parameter int unsigned NREQ = DEF_NREQ,
    parameter int unsigned IW   = idx_w(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [IW-1:0]   winner,
    output logic            any_req
);

    logic [IW-1:0] cand;

    always_comb begin
        winner  = '0;
        any_req = 1'b0;
        cand    = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            cand = IW'((32'(ptr) + i) % NREQ);
            if (!any_req && req[cand]) begin
                winner  = cand;
                any_req = 1'b1;
            end
        end
    end

endmodule

// File: rtl/reg_write_arbiter.sv
// reg_write_arbiter: round-robin arbiter owning a shared DW-bit register.
// Each tenure allows at most MAX_HOLD writes; one ARB cycle separates tenures.
//   clk, rst : rising-edge clock, asynchronous active-high reset
//   req      : per-requester level request
//   wdata    : requester i data in slice [i*DW +: DW]
//   gnt      : registered one-hot grant (zero when idle)
//   owner    : current owner index (valid while busy)
//   busy     : grant held
//   q        : shared register contents
//   upd      : high in the cycle after q was loaded
//   q_par    : even parity of q (only with REG_WRITE_ARB_PARITY_EN defined)
module reg_write_arbiter
    import reg_write_arb_pkg::*;
#(
    parameter int unsigned NREQ     = DEF_NREQ,
    parameter int unsigned DW       = DEF_DW,
    parameter int unsigned MAX_HOLD = DEF_MAX_HOLD
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NREQ-1:0]           req,
    input  logic [NREQ*DW-1:0]        wdata,
    output logic [NREQ-1:0]           gnt,
    output logic [idx_w(NREQ)-1:0]    owner,
    output logic                      busy,
    output logic [DW-1:0]             q,
    output logic                      upd
`ifdef REG_WRITE_ARB_PARITY_EN
    ,
    output logic                      q_par
`endif
);

    localparam int unsigned IW = idx_w(NREQ);
    localparam int unsigned HW = $clog2(MAX_HOLD + 1);

    if (MAX_HOLD < 1) begin : g_bad_hold
        $error("reg_write_arbiter: MAX_HOLD must be at least 1");
    end
    if (NREQ < 1 || NREQ > 16) begin : g_bad_nreq
        $error("reg_write_arbiter: NREQ must be in 1..16");
    end

    arb_state_e     state, state_n;
    logic [IW-1:0]  ptr, ptr_n, owner_n, winner;
    logic [HW-1:0]  hold_cnt, hold_n;
    logic [NREQ-1:0] gnt_n;
    logic [DW-1:0]  q_n;
    logic           upd_n, any_req, rel;

    rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
        .req     (req),
        .ptr     (ptr),
        .winner  (winner),
        .any_req (any_req)
    );

    always_comb begin
        state_n = state;
        ptr_n   = ptr;
        owner_n = owner;
        hold_n  = hold_cnt;
        gnt_n   = gnt;
        q_n     = q;
        upd_n   = 1'b0;
        rel     = 1'b0;
        unique case (state)
            ARB: begin
                if (any_req) begin
                    gnt_n   = NREQ'(1) << winner;
                    owner_n = winner;
                    hold_n  = '0;
                    state_n = OWN;
                end
            end
            OWN: begin
                // A dropped request releases without writing, even on the cap cycle.
                if (req[owner]) begin
                    q_n    = DW'(wdata >> (owner * DW));
                    upd_n  = 1'b1;
                    hold_n = hold_cnt + HW'(1);
                    rel    = (hold_cnt == HW'(MAX_HOLD - 1));
                end else begin
                    rel = 1'b1;
                end
                if (rel) begin
                    gnt_n   = '0;
                    ptr_n   = (owner == IW'(NREQ - 1)) ? '0 : owner + IW'(1);
                    state_n = ARB;
                end
            end
            default: state_n = ARB;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ARB;
            ptr      <= '0;
            owner    <= '0;
            hold_cnt <= '0;
            gnt      <= '0;
            q        <= '0;
            upd      <= 1'b0;
        end else begin
            state    <= state_n;
            ptr      <= ptr_n;
            owner    <= owner_n;
            hold_cnt <= hold_n;
            gnt      <= gnt_n;
            q        <= q_n;
            upd      <= upd_n;
        end
    end

`ifdef REG_WRITE_ARB_PARITY_EN
    // q_n equals q when nothing is written, so parity tracks the loaded value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) q_par <= 1'b0;
        else     q_par <= ^q_n;
    end
`endif

    assign busy = (state == OWN);

endmodule
